// File: rtl/washing_machine_water_fill_controller.sv
// Water fill controller: latches a target level, opens the inlet valve
// until reached, settles, tops up a bounded number of times, reports.
// Ports: clk, reset (async, active-high), start, clear, target_level,
//   sensor_level in; inlet_valve, busy, fill_done, fault, fault_code,
//   latched_target out (all registered).
module washing_machine_water_fill_controller #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd5000,
  parameter logic [7:0]  SETTLE_CYCLES  = 8'd8,
  parameter logic [9:0]  HYSTERESIS     = 10'd10,
  parameter logic [1:0]  MAX_REFILLS    = 2'd2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       clear,
  input  logic [9:0] target_level,
  input  logic [9:0] sensor_level,
  output logic       inlet_valve,
  output logic       busy,
  output logic       fill_done,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [9:0] latched_target
);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    SETTLE,
    DONE,
    FAULT
  } state_t;

  state_t      state_q;
  logic [15:0] timer_q;
  logic [7:0]  settle_q;
  logic [1:0]  refill_q;
  logic        valve_q;
  logic        busy_q;
  logic        done_q;
  logic        fault_q;
  logic [1:0]  code_q;
  logic [9:0]  lt_q;

  logic        reached;
  logic        timed_out;
  logic        settle_last;
  logic [10:0] level_sum;
  logic        level_ok;

  assign reached     = sensor_level >= lt_q;
  assign timed_out   = timer_q >= (TIMEOUT_CYCLES - 16'd1);
  assign settle_last = settle_q == (SETTLE_CYCLES - 8'd1);
  // 11-bit sum so a high reading plus margin cannot wrap
  assign level_sum   = {1'b0, sensor_level} + {1'b0, HYSTERESIS};
  assign level_ok    = level_sum >= {1'b0, lt_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      settle_q <= '0;
      refill_q <= '0;
      valve_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
      code_q   <= 2'b00;
      lt_q     <= '0;
    end else if (clear) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      settle_q <= '0;
      refill_q <= '0;
      valve_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
      code_q   <= 2'b00;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            timer_q  <= '0;
            settle_q <= '0;
            refill_q <= '0;
            lt_q     <= target_level;
            if (target_level == 10'd0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= FILL;
              valve_q <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
        end
        FILL: begin
          // cumulative across refills, saturating
          if (timer_q != 16'hFFFF) timer_q <= timer_q + 16'd1;
          if (reached) begin
            state_q  <= SETTLE;
            valve_q  <= 1'b0;
            settle_q <= '0;
          end else if (timed_out) begin
            state_q <= FAULT;
            valve_q <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b1;
            code_q  <= 2'b01;
          end
        end
        SETTLE: begin
          if (settle_last) begin
            settle_q <= '0;
            if (level_ok) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else if (refill_q < MAX_REFILLS) begin
              state_q  <= FILL;
              refill_q <= refill_q + 2'd1;
              valve_q  <= 1'b1;
            end else begin
              state_q <= FAULT;
              busy_q  <= 1'b0;
              fault_q <= 1'b1;
              code_q  <= 2'b10;
            end
          end else begin
            settle_q <= settle_q + 8'd1;
          end
        end
        DONE: begin
          state_q <= DONE;
        end
        FAULT: begin
          state_q <= FAULT;
        end
        default: begin
          state_q <= IDLE;
          valve_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign inlet_valve    = valve_q;
  assign busy           = busy_q;
  assign fill_done      = done_q;
  assign fault          = fault_q;
  assign fault_code     = code_q;
  assign latched_target = lt_q;

endmodule

// File: tb/tb_washing_machine_water_fill_controller.sv
// Bench for the water fill controller: a vector table for single-cycle
// behaviour plus hand sequences for fill, top-up, exhaustion, timeout.
module tb_washing_machine_water_fill_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       clear;
  logic [9:0] target_level;
  logic [9:0] sensor_level;
  logic       inlet_valve;
  logic       busy;
  logic       fill_done;
  logic       fault;
  logic [1:0] fault_code;
  logic [9:0] latched_target;

  int n_vec = 0;
  int n_bad = 0;

  washing_machine_water_fill_controller #(
    .TIMEOUT_CYCLES(16'd50)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .clear(clear),
    .target_level(target_level),
    .sensor_level(sensor_level),
    .inlet_valve(inlet_valve),
    .busy(busy),
    .fill_done(fill_done),
    .fault(fault),
    .fault_code(fault_code),
    .latched_target(latched_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st;
    logic       cl;
    logic [9:0] tg;
    logic [9:0] sn;
    logic       v;
    logic       b;
    logic       d;
    logic       f;
    logic [1:0] c;
    logic [9:0] lt;
  } vec_t;

  vec_t tv[$];

  function automatic void add(
    logic st, logic cl, logic [9:0] tg, logic [9:0] sn,
    logic v, logic b, logic d, logic f,
    logic [1:0] c, logic [9:0] lt);
    vec_t e;
    e.st = st; e.cl = cl; e.tg = tg; e.sn = sn;
    e.v = v; e.b = b; e.d = d; e.f = f;
    e.c = c; e.lt = lt;
    tv.push_back(e);
  endfunction

  task automatic chk(
    string nm, logic v, logic b, logic d, logic f,
    logic [1:0] c, logic [9:0] lt);
    logic [15:0] act;
    logic [15:0] exp;
    act = {inlet_valve, busy, fill_done, fault,
           fault_code, latched_target};
    exp = {v, b, d, f, c, lt};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got v%b b%b d%b f%b c%b lt%0d want v%b b%b d%b f%b c%b lt%0d",
               nm, act[15], act[14], act[13], act[12], act[11:10],
               act[9:0], v, b, d, f, c, lt);
    end
  endtask

  task automatic drive(logic st, logic cl, logic [9:0] tg,
                       logic [9:0] sn);
    @(negedge clk);
    start = st;
    clear = cl;
    target_level = tg;
    sensor_level = sn;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    clear = 1'b0;
    target_level = '0;
    sensor_level = '0;

    add(0, 0,   0,   0, 0, 0, 0, 0, 2'b00,   0);
    add(1, 0,   0,   0, 0, 0, 1, 0, 2'b00,   0);
    add(1, 0,   5,   0, 0, 0, 1, 0, 2'b00,   0);
    add(0, 1,   0,   0, 0, 0, 0, 0, 2'b00,   0);
    add(1, 1,  77,   0, 0, 0, 0, 0, 2'b00,   0);
    add(1, 0, 200,   0, 1, 1, 0, 0, 2'b00, 200);
    add(0, 0, 200, 199, 1, 1, 0, 0, 2'b00, 200);
    add(0, 0,  50, 200, 0, 1, 0, 0, 2'b00, 200);
    for (int i = 0; i < 7; i++)
      add(0, 0, 50, 200, 0, 1, 0, 0, 2'b00, 200);
    add(0, 0,  50, 190, 0, 0, 1, 0, 2'b00, 200);
    add(0, 0,  50, 190, 0, 0, 1, 0, 2'b00, 200);
    add(0, 1,  50,   0, 0, 0, 0, 0, 2'b00, 200);

    repeat (2) @(negedge clk);
    chk("reset", 0, 0, 0, 0, 2'b00, 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (tv[i]) begin
      drive(tv[i].st, tv[i].cl, tv[i].tg, tv[i].sn);
      chk($sformatf("vec%0d", i), tv[i].v, tv[i].b, tv[i].d,
          tv[i].f, tv[i].c, tv[i].lt);
    end

    // normal fill with +10 ramp
    drive(1, 0, 300, 0);
    chk("nf_start", 1, 1, 0, 0, 2'b00, 300);
    for (int k = 1; k <= 30; k++) begin
      drive(0, 0, 300, 10'(10 * k));
      chk($sformatf("nf_ramp%0d", k), (k < 30), 1, 0, 0,
          2'b00, 300);
    end
    for (int j = 1; j <= 8; j++) begin
      drive(0, 0, 300, 300);
      chk($sformatf("nf_settle%0d", j), 0, (j < 8), (j == 8), 0,
          2'b00, 300);
    end
    drive(0, 1, 0, 0);
    chk("nf_clear", 0, 0, 0, 0, 2'b00, 300);

    // top-up once
    drive(1, 0, 600, 0);
    chk("tu_start", 1, 1, 0, 0, 2'b00, 600);
    drive(0, 0, 600, 600);
    chk("tu_reach", 0, 1, 0, 0, 2'b00, 600);
    repeat (7) drive(0, 0, 600, 600);
    drive(0, 0, 600, 580);
    chk("tu_refill", 1, 1, 0, 0, 2'b00, 600);
    drive(0, 0, 600, 600);
    chk("tu_reach2", 0, 1, 0, 0, 2'b00, 600);
    repeat (7) drive(0, 0, 600, 600);
    chk("tu_settle", 0, 1, 0, 0, 2'b00, 600);
    drive(0, 0, 600, 600);
    chk("tu_done", 0, 0, 1, 0, 2'b00, 600);
    drive(0, 1, 0, 0);

    // refill exhaustion
    drive(1, 0, 150, 0);
    chk("rx_start", 1, 1, 0, 0, 2'b00, 150);
    for (int r = 0; r < 3; r++) begin
      drive(0, 0, 150, 150);
      chk($sformatf("rx_reach%0d", r), 0, 1, 0, 0, 2'b00, 150);
      repeat (7) drive(0, 0, 150, 150);
      drive(0, 0, 150, 100);
      if (r < 2)
        chk($sformatf("rx_refill%0d", r), 1, 1, 0, 0, 2'b00, 150);
      else
        chk("rx_fault", 0, 0, 0, 1, 2'b10, 150);
    end
    drive(1, 0, 20, 0);
    chk("rx_hold", 0, 0, 0, 1, 2'b10, 150);
    drive(0, 1, 0, 0);
    chk("rx_clear", 0, 0, 0, 0, 2'b00, 150);

    // timeout after 50 open cycles
    drive(1, 0, 900, 0);
    chk("to_start", 1, 1, 0, 0, 2'b00, 900);
    for (int k = 1; k <= 50; k++) begin
      drive(0, 0, 900, 0);
      if (k == 49) chk("to_open49", 1, 1, 0, 0, 2'b00, 900);
      if (k == 50) chk("to_fault", 0, 0, 0, 1, 2'b01, 900);
    end
    drive(1, 0, 100, 0);
    chk("to_ignore", 0, 0, 0, 1, 2'b01, 900);
    drive(0, 1, 0, 0);
    chk("to_clear", 0, 0, 0, 0, 2'b00, 900);

    // async reset mid-fill
    drive(1, 0, 300, 0);
    drive(0, 0, 300, 50);
    chk("ar_fill", 1, 1, 0, 0, 2'b00, 300);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("ar_async", 0, 0, 0, 0, 2'b00, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(1, 0, 100, 0);
    chk("ar_restart", 1, 1, 0, 0, 2'b00, 100);
    drive(0, 0, 100, 100);
    chk("ar_reach", 0, 1, 0, 0, 2'b00, 100);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/washing_machine_water_fill_controller.md
Name: washing_machine_water_fill_controller

Overview:
Downstream consumer of the load-size detection stage. It latches the 10-bit target water level produced from the load weight and drives the inlet valve until the tank's 10-bit level sensor reaches that target. After filling it waits a settle period, tops up a bounded number of times if the level drops, and reports completion or a fault to the wash-cycle sequencer.

Parameters:
TIMEOUT_CYCLES, 16'd5000, maximum cumulative cycles the valve may be open per fill request (all refills included)
SETTLE_CYCLES, 8'd8, cycles to wait with the valve closed before re-checking the level
HYSTERESIS, 10'd10, allowed shortfall below target after settling before a refill is triggered
MAX_REFILLS, 2'd2, maximum refill attempts per request

Ports:
clk  input  1  clock
reset  input  1  async active-high reset
start  input  1  one-cycle fill request from sequencer
clear  input  1  abort/acknowledge; returns block to IDLE from any state
target_level  input  10  required water level from load-size detection stage
sensor_level  input  10  current tank level sensor reading
inlet_valve  output  1  1 = inlet valve open
busy  output  1  1 while in FILL or SETTLE
fill_done  output  1  level held high in DONE
fault  output  1  level held high in FAULT
fault_code  output  2  00 none, 01 timeout, 10 refills exhausted
latched_target  output  10  target captured at start

Behaviour:
- Reset is asynchronous and active-high on reset. Clock is clk. All logic is rising-edge triggered. All outputs are registered.
- Reset values: state IDLE; all outputs 0; internal fill timer, settle counter and refill count 0.
- States: IDLE, FILL, SETTLE, DONE, FAULT.
- clear has highest priority in every state. Next cycle: state IDLE, inlet_valve=0, fill_done=0, fault=0, fault_code=00, counters 0. latched_target keeps its value.
- IDLE:
  - start=1 and target_level==0: go to DONE, latched_target=0, valve never opens.
  - start=1 and target_level!=0: latch target_level, go to FILL. inlet_valve=1 and busy=1 from the next cycle.
- FILL:
  - Fill timer increments once per cycle while in FILL. It is not cleared on refill and saturates at its maximum.
  - sensor_level >= latched_target (equality counts as reached): go to SETTLE, inlet_valve=0, settle counter cleared.
  - Otherwise, if the timer reaches TIMEOUT_CYCLES-1: go to FAULT, fault_code=01, inlet_valve=0.
  - The level check has priority over the timeout in the same cycle.
- SETTLE:
  - The settle counter counts SETTLE_CYCLES cycles. The evaluation happens in the cycle where the counter equals SETTLE_CYCLES-1.
  - Evaluation compares sensor_level+HYSTERESIS against latched_target. The sum is computed 11 bits wide, with no overflow wrap.
  - If sensor_level+HYSTERESIS >= latched_target: go to DONE.
  - Else if refill count < MAX_REFILLS: increment refill count, go to FILL, valve reopens.
  - Else: go to FAULT, fault_code=10.
- DONE: fill_done=1, busy=0, valve closed. start is ignored. Exits only via clear.
- FAULT: fault=1, valve closed, fault_code held. start is ignored. Exits only via clear.
- start is ignored outside IDLE. target_level changes after latching have no effect.
- start and clear asserted in the same cycle: clear wins and the start is dropped.
- Reset mid-fill: the valve closes immediately (asynchronous) and the request is discarded.
- busy = (state==FILL or SETTLE). inlet_valve is 1 only in FILL.

Test Plan:
- Normal fill: target 300, start pulse, sensor ramps +10 per cycle from 0 -> inlet_valve=1 from cycle 1 until sensor reaches 300; after 8 settle cycles with sensor=300, fill_done=1, fault_code=00.
- Top-up: target 600, sensor hits 600, then drops to 580 during settle -> one refill, valve reopens; sensor returns to 600, then fill_done=1.
- Refill exhaustion: target 150, sensor toggles 150 and then 100 during each settle -> 2 refills, then fault=1, fault_code=10, valve=0.
- Timeout: TIMEOUT_CYCLES=50, target 900, sensor fixed at 0 -> valve open for 50 cycles, then fault=1, fault_code=01; start ignored until clear.
- Edge cases: target 0 gives fill_done=1 with the valve never open. start+clear in the same cycle stays IDLE. Sensor exactly equal to target ends FILL.
- Async reset asserted mid-FILL -> inlet_valve=0 immediately, all outputs 0; a new start after release behaves normally.
